// File: rtl/fpu_pkg.sv
// Shared encodings and helpers for the fixed-point ALU.
package fpu_pkg;

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] SQRT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // One root bit per iteration over the radicand padded to an even width.
  function automatic int unsigned sqrt_iters(input int unsigned width, input int unsigned fbits);
    return (width + fbits + 1) / 2;
  endfunction

endpackage

// File: rtl/fpu_chunk_multiplier.sv
// Combinational unsigned MUL_CHUNK x MUL_CHUNK partial-product multiplier.
module fpu_chunk_multiplier #(
  parameter int unsigned MUL_CHUNK = 16
) (
  input  logic [MUL_CHUNK-1:0]   a,
  input  logic [MUL_CHUNK-1:0]   b,
  output logic [2*MUL_CHUNK-1:0] product
);
  localparam int unsigned PW = 2 * MUL_CHUNK;

  assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/fixed_point_alu.sv
// Fixed-point ALU: single-cycle add/sub, iterative multiply and square root.
// Define FPU_SATURATE_EN to clamp ADD/SUB/MUL results on signed overflow.
module fixed_point_alu
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FBITS     = 10,
  parameter int unsigned MUL_CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             overflow
);
  localparam int unsigned K     = WIDTH / MUL_CHUNK;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned AW    = 2 * WIDTH;
  localparam int unsigned PW    = 2 * MUL_CHUNK;
  localparam int unsigned SQ_N  = sqrt_iters(WIDTH, FBITS);
  localparam int unsigned RAD_W = 2 * SQ_N;
  localparam int unsigned REM_W = SQ_N + 2;
  localparam int unsigned CNT_W = $clog2(SQ_N + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_prod, neg_rad;
  logic [KW-1:0]    ci, cj;
  logic [AW-1:0]    acc;
  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem;
  logic [SQ_N-1:0]  root;
  logic [CNT_W-1:0] cnt;

  // ADD/SUB straight from the ports: the result is registered on the accepting edge.
  logic             is_sub, as_ovf;
  logic [WIDTH-1:0] b_eff, as_sum, as_res;

  assign is_sub = (operation == FPU_SUB);
  assign b_eff  = is_sub ? ~operand_2 : operand_2;
  assign as_sum = operand_1 + b_eff + WIDTH'(is_sub);
  assign as_ovf = (operand_1[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (as_sum[WIDTH-1] != operand_1[WIDTH-1]);

  logic [MUL_CHUNK-1:0] a_chunk, b_chunk;
  logic [PW-1:0]        pp;
  logic [AW-1:0]        pp_sh, acc_sum, acc_next;
  logic                 mul_last, mul_ovf;
  logic [WIDTH-1:0]     mul_res;

  assign a_chunk = MUL_CHUNK'(mag_a >> (32'(ci) * MUL_CHUNK));
  assign b_chunk = MUL_CHUNK'(mag_b >> (32'(cj) * MUL_CHUNK));

  fpu_chunk_multiplier #(.MUL_CHUNK(MUL_CHUNK)) u_chunk_mul (
    .a       (a_chunk),
    .b       (b_chunk),
    .product (pp)
  );

  assign pp_sh    = AW'(pp) << ((32'(ci) + 32'(cj)) * MUL_CHUNK);
  assign acc_sum  = acc + pp_sh;
  assign mul_last = (ci == KW'(K - 1)) && (cj == KW'(K - 1));
  assign acc_next = (mul_last && neg_prod) ? -acc_sum : acc_sum;
  assign mul_ovf  = !((&acc_next[AW-1:WIDTH+FBITS-1]) || !(|acc_next[AW-1:WIDTH+FBITS-1]));

`ifdef FPU_SATURATE_EN
  function automatic logic [WIDTH-1:0] clamp(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign as_res  = as_ovf  ? clamp(operand_1[WIDTH-1]) : as_sum;
  assign mul_res = mul_ovf ? clamp(neg_prod) : acc_next[WIDTH+FBITS-1:FBITS];
`else
  assign as_res  = as_sum;
  assign mul_res = acc_next[WIDTH+FBITS-1:FBITS];
`endif

  // Restoring square root: bring down two radicand bits, try (root<<2)|1.
  logic [REM_W-1:0] rem_sh, trial, rem_nx;
  logic [SQ_N-1:0]  root_nx;
  logic             sq_ge, sq_last, sq_unused;

  assign rem_sh    = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
  assign trial     = {root, 2'b01};
  assign sq_ge     = (rem_sh >= trial);
  assign rem_nx    = sq_ge ? (rem_sh - trial) : rem_sh;
  assign root_nx   = {root[SQ_N-2:0], sq_ge};
  assign sq_last   = (cnt == CNT_W'(SQ_N - 1));
  assign sq_unused = ^rem[REM_W-1 -: 2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      result   <= '0;
      overflow <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_prod <= 1'b0;
      neg_rad  <= 1'b0;
      ci       <= '0;
      cj       <= '0;
      acc      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mag_a    <= operand_1[WIDTH-1] ? -operand_1 : operand_1;
            mag_b    <= operand_2[WIDTH-1] ? -operand_2 : operand_2;
            neg_prod <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
            neg_rad  <= operand_1[WIDTH-1];
            rad      <= RAD_W'({operand_1, {FBITS{1'b0}}});
            acc      <= '0;
            ci       <= '0;
            cj       <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            case (operation)
              FPU_ADD, FPU_SUB: begin
                result   <= as_res;
                overflow <= as_ovf;
                state    <= DONE;
              end
              FPU_MUL: state <= MUL;
              default: state <= SQRT;
            endcase
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (mul_last) begin
            result   <= mul_res;
            overflow <= mul_ovf;
            state    <= DONE;
          end else if (cj == KW'(K - 1)) begin
            cj <= '0;
            ci <= ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end
        SQRT: begin
          rem  <= rem_nx;
          root <= root_nx;
          rad  <= rad << 2;
          cnt  <= cnt + 1'b1;
          if (sq_last) begin
            result   <= neg_rad ? '0 : WIDTH'(root_nx);
            overflow <= neg_rad;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state == MUL) || (state == SQRT);

endmodule

// File: tb/tb_fixed_point_alu.sv
// Scoreboard bench for fixed_point_alu: expected result, flag and latency per accepted op.
module tb_fixed_point_alu;
  import fpu_pkg::*;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned FBITS     = 10;
  localparam int unsigned MUL_CHUNK = 16;
  localparam int LAT_AS  = 1;
  localparam int LAT_MUL = (WIDTH / MUL_CHUNK) * (WIDTH / MUL_CHUNK) + 1;
  localparam int LAT_SQ  = (WIDTH + FBITS + 1) / 2 + 1;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    int               acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       operation = FPU_ADD;
  logic [WIDTH-1:0] operand_1 = '0;
  logic [WIDTH-1:0] operand_2 = '0;
  logic [WIDTH-1:0] result;
  logic             ready, busy, overflow;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];

  fixed_point_alu #(.WIDTH(WIDTH), .FBITS(FBITS), .MUL_CHUNK(MUL_CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .result    (result),
    .ready     (ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit signed integers.
  function automatic void model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                output logic o);
    longint sa, sbv, t;
    longint unsigned x, root, cand;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == FPU_SQRT) begin
      o    = (sa < 0);
      x    = 64'(a) << FBITS;
      root = 0;
      for (int i = 23; i >= 0; i--) begin
        cand = root | (64'd1 << i);
        if (cand * cand <= x) root = cand;
      end
      r = o ? '0 : WIDTH'(root);
    end else begin
      if (op == FPU_ADD)      t = sa + sbv;
      else if (op == FPU_SUB) t = sa - sbv;
      else                    t = (sa * sbv) >>> FBITS;
      o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      r = WIDTH'(t);
`ifdef FPU_SATURATE_EN
      if (o) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    end
  endfunction

  task automatic issue(input string tag, input logic [1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.tag = tag;
    model(op, a, b, e.res, e.ovf);
    e.lat     = (op == FPU_MUL) ? LAT_MUL : (op == FPU_SQRT) ? LAT_SQ : LAT_AS;
    e.acc_cyc = cyc + 1;
    operation = op;
    operand_1 = a;
    operand_2 = b;
    start     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    operand_1 = $urandom;
    operand_2 = $urandom;
    operation = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(output int bc);
    bc = busy ? 1 : 0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 64'(ready), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, 64'(result), 64'(e.res));
        check({e.tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        check({e.tag, "_lat"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int bc;
    #2 reset = 1'b0;
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue("add", FPU_ADD, 32'h0000_0C00, 32'h0000_0800); wait_idle(bc);
    issue("sub", FPU_SUB, 32'h0000_0C00, 32'h0000_0800); wait_idle(bc);
    issue("mul", FPU_MUL, 32'h0000_0C00, 32'h0000_0800); wait_idle(bc);
    check("mul_busy_cycles", 64'(bc), 64'd4);
    issue("mul_neg", FPU_MUL, 32'hFFFF_FA00, 32'h0000_0800);   wait_idle(bc);
    issue("sqrt4", FPU_SQRT, 32'h0000_1000, 32'h0);            wait_idle(bc);
    issue("sqrt2", FPU_SQRT, 32'h0000_0800, 32'h0);            wait_idle(bc);
    issue("sqrt_neg", FPU_SQRT, 32'hFFFF_F000, 32'h0);         wait_idle(bc);
    issue("mul_ovf", FPU_MUL, 32'h7FFF_FC00, 32'h0000_0800);   wait_idle(bc);
    issue("mul_minneg", FPU_MUL, 32'h8000_0000, 32'h0000_0400); wait_idle(bc);
    issue("mul_minsq", FPU_MUL, 32'h8000_0000, 32'h8000_0000); wait_idle(bc);
    issue("add_ovf", FPU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);   wait_idle(bc);
    issue("sub_ovf", FPU_SUB, 32'h0000_0000, 32'h8000_0000);   wait_idle(bc);
    issue("add_zero", FPU_ADD, 32'h0, 32'h0);                  wait_idle(bc);
    issue("mul_zero", FPU_MUL, 32'h0, 32'h0);                  wait_idle(bc);
    issue("sqrt_zero", FPU_SQRT, 32'h0, 32'h0);                wait_idle(bc);

    for (int i = 0; i < 4; i++) begin
      issue("mul_rnd", FPU_MUL, $urandom, 32'($urandom_range(0, 32'h0003_FFFF)));
      wait_idle(bc);
      issue("sqrt_rnd", FPU_SQRT, {1'b0, 31'($urandom)}, 32'h0);
      wait_idle(bc);
    end

    // start held high while the multiplier is busy must not be queued.
    issue("mul_ign", FPU_MUL, 32'h0000_0C00, 32'h0000_0800);
    operation = FPU_ADD;
    operand_1 = 32'h1;
    operand_2 = 32'h1;
    start     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle(bc);
    repeat (8) @(negedge clk);

    // Second request issued in the DONE cycle of the first.
    issue("b2b_add", FPU_ADD, 32'h0000_1000, 32'hFFFF_FC00);
    issue("b2b_mul", FPU_MUL, 32'hFFFF_F800, 32'hFFFF_FA00);
    wait_idle(bc);
    repeat (3) @(negedge clk);

    issue("sqrt_abort", FPU_SQRT, 32'h0000_1000, 32'h0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);
    issue("add_after_rst", FPU_ADD, 32'h0000_0400, 32'h0000_0400);
    wait_idle(bc);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_alu.md
Name: fixed_point_alu

Overview:
- Parametrised, handshaked successor to the current fixed-point unit.
- Signed two's-complement Q(WIDTH-FBITS).FBITS arithmetic: add, subtract, multiply and square root.
- Multiply and square root are iterative multi-cycle engines sharing one start/ready handshake, with a registered result and an overflow/error flag.
- Sits beside the integer ALU in the execute stage; execute stalls on busy.

Parameters:
- WIDTH, 32: operand/result width in bits.
- FBITS, 10: fractional bits; must be < WIDTH.
- MUL_CHUNK, 16: partial-multiplier operand width; WIDTH must be a multiple of it. K = WIDTH/MUL_CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a clk edge only while busy=0.
- operation  in  2  op select: FPU_ADD=0, FPU_SUB=1, FPU_MUL=2, FPU_SQRT=3.
- operand_1  in  WIDTH  first operand; the radicand for SQRT.
- operand_2  in  WIDTH  second operand; ignored for SQRT.
- result  out  WIDTH  registered result; held until the next accepted start.
- ready  out  1  one-cycle pulse when result is valid.
- busy  out  1  high while a MUL/SQRT is in progress.
- overflow  out  1  valid with ready; signed overflow (ADD/SUB/MUL) or negative radicand (SQRT).

Behaviour:
- Reset (reset=0, async):
  - result=0, ready=0, busy=0, overflow=0, state=IDLE.
  - Any in-flight operation is aborted; no ready pulse follows release.
- Operands and operation are captured on the accepting edge. Later input changes have no effect on that operation.
- States: IDLE, MUL, SQRT, DONE.
  - IDLE + start, ADD/SUB → DONE.
  - IDLE + start, MUL → MUL.
  - IDLE + start, SQRT → SQRT.
  - MUL or SQRT, last iteration → DONE.
  - DONE → IDLE. start is also accepted in DONE (back-to-back) with the same transitions as IDLE.
- ready is high exactly while in DONE. busy is high in MUL and SQRT.
- start while busy=1 is ignored and not queued.
- Latency, in edges from the accepting edge to the first edge where ready=1:
  - ADD/SUB: 1.
  - MUL: K*K + 1 (5 at defaults).
  - SQRT: ceil((WIDTH+FBITS)/2) + 1 (22 at defaults).
- ADD/SUB:
  - WIDTH-bit wrap result.
  - overflow = operands' signs agree (for SUB, operand_1 vs inverted operand_2) and the result sign differs.
- MUL:
  - Magnitudes of both operands taken into WIDTH-bit unsigned. The most-negative value is handled exactly.
  - One MUL_CHUNK x MUL_CHUNK partial product per cycle, chunk pairs in row-major order.
  - Each partial product is shifted and added into a 2*WIDTH accumulator.
  - Final cycle negates the accumulator if the operand signs differ.
  - result = acc[WIDTH+FBITS-1:FBITS], which truncates toward minus infinity.
  - overflow = acc[2*WIDTH-1:WIDTH+FBITS-1] is not all-equal.
- SQRT:
  - Radicand = operand_1 << FBITS, zero-padded to an even width.
  - Restoring digit-by-digit algorithm, one result bit per cycle.
  - result = floor(sqrt), zero-extended.
  - Negative operand_1: the iterations still run; result=0 and overflow=1.
- Zero operands give result 0 with overflow 0 for every op.

Optional Feature:
- Macro FPU_SATURATE_EN.
- Defined: on ADD/SUB/MUL overflow, result clamps to 0x7FF..F (positive true result) or 0x800..0 (negative); overflow still asserts.
- Undefined: wrap/truncate as above. Identical latency either way.

Decomposition:
- Shared package fpu_pkg holds:
  - operation encodings FPU_ADD/SUB/MUL/SQRT;
  - state encoding IDLE/MUL/SQRT/DONE;
  - the SQRT iteration-count function.
- One sub-module, fpu_chunk_multiplier: combinational unsigned MUL_CHUNK x MUL_CHUNK → 2*MUL_CHUNK product, instantiated once and time-multiplexed by the MUL state.

Test Plan:
- ADD 0x00000C00 (3.0) + 0x00000800 (2.0) → result 0x00001400, ready 1 edge after start, overflow 0. SUB with the same operands → 0x00000400.
- MUL 0x00000C00 * 0x00000800 → 0x00001800, ready exactly 5 edges after start, busy high for 4 cycles. MUL 0xFFFFFA00 (-1.5) * 0x00000800 → 0xFFFFF400.
- SQRT 0x00001000 (4.0) → 0x00000800 at edge 22. SQRT 0x00000800 (2.0) → 0x000005A8. SQRT 0xFFFFF000 → result 0, overflow 1.
- MUL 0x7FFFFC00 * 0x00000800 → overflow 1; result 0xFFFFF800 without FPU_SATURATE_EN, 0x7FFFFFFF with it.
- start pulsed again at edge 2 of a MUL → ignored, single ready. start asserted during DONE → accepted, second result correct.
- reset driven low at edge 10 of a SQRT → all outputs 0 immediately, no ready after release. A fresh ADD then completes normally.
